// File: rtl/alu_dispatch.sv
// alu_dispatch: single-issue dispatcher that routes one instruction at a time to a
// functional unit, waits UNIT_LATENCY edges, then holds the captured result until taken.
module alu_dispatch #(
    parameter int UNIT_LATENCY = 1
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       In_Valid,
    output logic       In_Ready,
    input  logic [3:0] In_Opcode,
    input  logic [7:0] In_A,
    input  logic [7:0] In_B,
    output logic [3:0] Opcode,
    output logic [7:0] A,
    output logic [7:0] B,
    output logic [2:0] Select,
    input  logic [7:0] Unit_Result,
    input  logic       Unit_Flag,
    output logic       Out_Valid,
    input  logic       Out_Ready,
    output logic [7:0] Out_Result,
    output logic       Out_Flag,
    output logic [3:0] Out_Opcode,
    output logic       Error
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
    state_t     state, state_nxt;
    logic [3:0] cnt;
    logic       accept, illegal;
    assign accept  = In_Valid && In_Ready;
    assign illegal = In_Opcode == 4'hF;
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end
    always_comb begin
        state_nxt = state;
        if (state == IDLE)      state_nxt = accept ? (illegal ? DONE : WAIT) : IDLE;
        else if (state == WAIT) state_nxt = (cnt == 4'd0) ? DONE : WAIT;
        else                    state_nxt = Out_Ready ? IDLE : DONE;
    end
    always_comb begin
        In_Ready  = state == IDLE;
        Out_Valid = state == DONE;
    end
    // Illegal opcodes complete immediately with a zero result and never wake a unit.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt        <= 4'd0;
            Opcode     <= 4'd0;
            A          <= 8'd0;
            B          <= 8'd0;
            Select     <= 3'b111;
            Out_Result <= 8'd0;
            Out_Flag   <= 1'b0;
            Out_Opcode <= 4'd0;
            Error      <= 1'b0;
        end else if (accept) begin
            Opcode <= In_Opcode;
            A      <= In_A;
            B      <= In_B;
            Select <= illegal ? 3'b111 : {1'b0, In_Opcode[3:2]};
            cnt    <= illegal ? 4'd0 : 4'(UNIT_LATENCY);
            if (illegal) begin
                Out_Result <= 8'd0;
                Out_Flag   <= 1'b0;
                Out_Opcode <= In_Opcode;
                Error      <= 1'b1;
            end
        end else if (state == WAIT) begin
            if (cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end else begin
                Out_Result <= Unit_Result;
                Out_Flag   <= Unit_Flag;
                Out_Opcode <= Opcode;
                Error      <= 1'b0;
                Select     <= 3'b111;
            end
        end
    end
endmodule

// File: doc/alu_dispatch.md
ALU_DISPATCH -- requirements
Module: alu_dispatch

Interface
REQ-001 Parameter: UNIT_LATENCY, default 1, number of Clk edges a functional unit takes from sampling Opcode/A/B/Select to presenting Unit_Result/Unit_Flag; legal range 1-15.
REQ-002 Clk  input  1  clock; all state updates on rising edge.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 In_Valid  input  1  upstream instruction valid.
REQ-005 In_Ready  output  1  dispatcher can accept an instruction.
REQ-006 In_Opcode  input  4  instruction opcode.
REQ-007 In_A, In_B  input  8 each  operands.
REQ-008 Opcode  output  4  registered opcode to functional units.
REQ-009 A, B  output  8 each  registered operands to functional units.
REQ-010 Select  output  3  unit select: 000 arith, 001 logic, 010 shift, 011 compare, 111 none.
REQ-011 Unit_Result  input  8  result returned by the selected unit.
REQ-012 Unit_Flag  input  1  flag returned by the selected unit.
REQ-013 Out_Valid  output  1  result available downstream.
REQ-014 Out_Ready  input  1  downstream accepts result.
REQ-015 Out_Result  output  8  captured result.
REQ-016 Out_Flag  output  1  captured unit flag.
REQ-017 Out_Opcode  output  4  opcode of the completed instruction.
REQ-018 Error  output  1  completed instruction had an illegal opcode.

Function
REQ-019 FSM states SHALL be IDLE, WAIT, DONE; one instruction in flight at a time.
REQ-020 In_Ready SHALL equal 1 only in IDLE; acceptance = In_Valid && In_Ready at a rising edge.
REQ-021 On acceptance, the block SHALL register In_Opcode/In_A/In_B onto Opcode/A/B and drive Select decoded from In_Opcode[3:2]: 00->000, 01->001, 10->010, 11->011.
REQ-022 Opcode 4'b1111 SHALL be illegal: Select stays 111, FSM goes IDLE->DONE on the acceptance edge, Out_Result=0, Out_Flag=0, Error=1.
REQ-023 Legal acceptance SHALL go IDLE->WAIT and load a wait counter with UNIT_LATENCY.
REQ-024 In WAIT, counter SHALL decrement each edge while nonzero; on the edge where counter==0, Unit_Result/Unit_Flag SHALL be captured into Out_Result/Out_Flag, Out_Opcode loaded, Error=0, FSM->DONE.
REQ-025 Out_Valid SHALL rise exactly UNIT_LATENCY+1 edges after the acceptance edge for legal opcodes, 1 edge after for illegal.
REQ-026 Opcode/A/B/Select SHALL hold stable throughout WAIT.
REQ-027 Select SHALL be 111 in IDLE and DONE, so units hold their outputs.
REQ-028 Out_Valid SHALL be 1 only in DONE; Out_Result/Out_Flag/Out_Opcode/Error SHALL hold stable while Out_Valid=1 and Out_Ready=0.
REQ-029 On Out_Valid && Out_Ready at an edge, FSM SHALL go DONE->IDLE; In_Ready rises the following cycle (no same-cycle accept).
REQ-030 In_Valid, In_Opcode, In_A, In_B SHALL be ignored outside IDLE.
REQ-031 Out_Result/Out_Flag/Out_Opcode/Error SHALL retain last values after returning to IDLE until the next capture.

Reset
REQ-032 Reset SHALL asynchronously force IDLE, counter=0, Opcode=0, A=0, B=0, Select=111, Out_Valid=0, Out_Result=0, Out_Flag=0, Out_Opcode=0, Error=0, In_Ready=1 after release.
REQ-033 Reset asserted in WAIT or DONE SHALL abandon the instruction; no Out_Valid pulse for it after release.

Verification
REQ-034 UNIT_LATENCY=1, accept 1100 A=0x20 B=0x10, unit model returns 0x01/flag 1 one edge after Select=011 -> Out_Valid at accept+2, Out_Result=0x01, Out_Flag=1, Out_Opcode=1100, Error=0.
REQ-035 Accept 1111 A=0x55 B=0xAA -> Select never leaves 111, Out_Valid at accept+1, Out_Result=0x00, Error=1.
REQ-036 UNIT_LATENCY=3, accept 0000 A=0xFF B=0x01; hold Out_Ready=0 for 5 cycles -> Out_Valid at accept+4, outputs stable 5 cycles, In_Ready=0 throughout, In_Valid pulses ignored.
REQ-037 Reset pulsed two cycles after accepting 1101 with UNIT_LATENCY=3 -> all outputs at reset values, Select=111, no Out_Valid until a new acceptance.
REQ-038 Back-to-back: In_Valid held high with opcodes 0100 then 1110, Out_Ready=1 -> second acceptance occurs one cycle after DONE exit; Select sequence 111,001,...,111,011; two Out_Valid pulses in order.
